// File: rtl/operand_vector_packer.sv
// Collects (a,b) operand pairs into a zero-padded vector and presents it, with its
// populated length, to a downstream inner-product stage through a one-deep output register.
module operand_vector_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int VECTOR_LEN = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [DATA_WIDTH-1:0]                          in_a,
    input  logic [DATA_WIDTH-1:0]                          in_b,
    input  logic                                           in_last,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [2*VECTOR_LEN-1:0][DATA_WIDTH-1:0]        data_out,
    output logic [$clog2(VECTOR_LEN+1)-1:0]                out_len
);

    localparam int IDX_W = $clog2(VECTOR_LEN);
    localparam int LEN_W = $clog2(VECTOR_LEN + 1);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(VECTOR_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                                     state_q, state_d;
    logic [IDX_W-1:0]                           idx_q, idx_d;
    logic [2*VECTOR_LEN-1:0][DATA_WIDTH-1:0]    fill_buf_q, fill_buf_d;
    logic [LEN_W-1:0]                           fill_len_q, fill_len_d;
    logic                                       out_valid_q, out_valid_d;
    logic [2*VECTOR_LEN-1:0][DATA_WIDTH-1:0]    data_out_q, data_out_d;
    logic [LEN_W-1:0]                           out_len_q, out_len_d;

    logic handshake;
    logic completing;
    logic out_free;

    // in_ready drops combinationally with rst so nothing is accepted during a reset cycle
    assign in_ready   = (state_q == FILL) && rst;
    assign handshake  = in_valid && in_ready;
    assign completing = handshake && ((idx_q == IDX_MAX) || in_last);
    assign out_free   = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            fill_buf_q  <= '0;
            fill_len_q  <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            out_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_buf_q  <= fill_buf_d;
            fill_len_q  <= fill_len_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            out_len_q   <= out_len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_buf_d  = fill_buf_q;
        fill_len_d  = fill_len_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        out_len_d   = out_len_q;

        // Lanes above the completing index are cleared so stale data never reaches the sum
        for (int k = 0; k < VECTOR_LEN; k++) begin
            if (handshake && (k == int'(idx_q))) begin
                fill_buf_d[2*k]     = in_a;
                fill_buf_d[2*k + 1] = in_b;
            end else if (completing && (k > int'(idx_q))) begin
                fill_buf_d[2*k]     = '0;
                fill_buf_d[2*k + 1] = '0;
            end
        end

        if (completing) begin
            fill_len_d = {1'b0, idx_q} + LEN_ONE;
            idx_d      = '0;
            state_d    = HOLD;
        end else if (handshake) begin
            idx_d = idx_q + IDX_ONE;
        end

        // A transfer into a slot being consumed in the same cycle keeps out_valid high
        if ((state_q == HOLD) && out_free) begin
            data_out_d  = fill_buf_q;
            out_len_d   = fill_len_q;
            out_valid_d = 1'b1;
            state_d     = FILL;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign out_len   = out_len_q;

endmodule

// File: tb/tb_operand_vector_packer.sv
// Directed bench for operand_vector_packer at VECTOR_LEN=4, DATA_WIDTH=8.
module tb_operand_vector_packer;

    localparam int DW = 8;
    localparam int VL = 4;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [DW-1:0]             in_a;
    logic [DW-1:0]             in_b;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*VL-1:0][DW-1:0]   data_out;
    logic [$clog2(VL+1)-1:0]   out_len;

    int tests_run;
    int fails;

    operand_vector_packer #(
        .DATA_WIDTH(DW),
        .VECTOR_LEN(VL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .out_len  (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'hAA;
        in_b     = 8'hBB;
        in_last  = 1'b1;
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_len !== 3'd0) begin fails++; $display("FAIL reset_out_len got %0d want 0", out_len); end
        tests_run++;
        if (data_out !== 64'h0) begin fails++; $display("FAIL reset_data_out got %h want 0", data_out); end
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_full();
        logic [2*VL-1:0][DW-1:0] exp_vec;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h55;
        in_last   = 1'b1;
        tick();
        in_last   = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL full_idle_ignored got in_ready=%b want 1", in_ready); end
        for (int i = 0; i < VL; i++) drive_pair(DW'(2*i + 1), DW'(2*i + 2), 1'b0);
        tests_run++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL full_hold_in_ready got %b want 0", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL full_latency_early got %b want 0", out_valid); end
        tick();
        for (int e = 0; e < 2*VL; e++) exp_vec[e] = DW'(e + 1);
        tests_run++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL full_out_valid got %b want 1", out_valid); end
        tests_run++;
        if (data_out !== exp_vec) begin fails++; $display("FAIL full_data got %h want %h", data_out, exp_vec); end
        tests_run++;
        if (out_len !== 3'd4) begin fails++; $display("FAIL full_len got %0d want 4", out_len); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL full_consume got %b want 0", out_valid); end
    endtask

    task automatic test_short();
        logic [2*VL-1:0][DW-1:0] exp_vec;
        drive_pair(8'd9, 8'd10, 1'b0);
        drive_pair(8'd11, 8'd12, 1'b1);
        tick();
        exp_vec = '0;
        exp_vec[0] = 8'd9; exp_vec[1] = 8'd10; exp_vec[2] = 8'd11; exp_vec[3] = 8'd12;
        tests_run++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL short_out_valid got %b want 1", out_valid); end
        tests_run++;
        if (data_out !== exp_vec) begin fails++; $display("FAIL short_data got %h want %h", data_out, exp_vec); end
        tests_run++;
        if (out_len !== 3'd2) begin fails++; $display("FAIL short_len got %0d want 2", out_len); end
        tick();
        drive_pair(8'd21, 8'd22, 1'b1);
        tick();
        exp_vec = '0;
        exp_vec[0] = 8'd21; exp_vec[1] = 8'd22;
        tests_run++;
        if (data_out !== exp_vec) begin fails++; $display("FAIL short_next_lane0 got %h want %h", data_out, exp_vec); end
        tests_run++;
        if (out_len !== 3'd1) begin fails++; $display("FAIL short_next_len got %0d want 1", out_len); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [2*VL-1:0][DW-1:0] vec_a;
        logic [2*VL-1:0][DW-1:0] vec_b;
        for (int e = 0; e < 2*VL; e++) begin
            vec_a[e] = DW'(8'h11 + e);
            vec_b[e] = DW'(8'h21 + e);
        end
        out_ready = 1'b0;
        for (int i = 0; i < VL; i++) drive_pair(vec_a[2*i], vec_a[2*i+1], 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || data_out !== vec_a) begin
            fails++; $display("FAIL bp_first_vector got v=%b %h want v=1 %h", out_valid, data_out, vec_a);
        end
        for (int i = 0; i < VL; i++) drive_pair(vec_b[2*i], vec_b[2*i+1], 1'b0);
        tests_run++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready got %b want 0", in_ready); end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || data_out !== vec_a) begin
            fails++; $display("FAIL bp_held got v=%b %h want v=1 %h", out_valid, data_out, vec_a);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_still_hold got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_no_bubble got %b want 1", out_valid); end
        tests_run++;
        if (data_out !== vec_b) begin fails++; $display("FAIL bp_second_vector got %h want %h", data_out, vec_b); end
        tests_run++;
        if (out_len !== 3'd4) begin fails++; $display("FAIL bp_len got %0d want 4", out_len); end
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_back_to_fill got %b want 1", in_ready); end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_single();
        logic [2*VL-1:0][DW-1:0] exp_vec;
        drive_pair(8'hFF, 8'h01, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early got %b want 0", out_valid); end
        tick();
        exp_vec = '0;
        exp_vec[0] = 8'hFF; exp_vec[1] = 8'h01;
        tests_run++;
        if (out_valid !== 1'b1 || data_out !== exp_vec) begin
            fails++; $display("FAIL single_data got v=%b %h want v=1 %h", out_valid, data_out, exp_vec);
        end
        tests_run++;
        if (out_len !== 3'd1) begin fails++; $display("FAIL single_len got %0d want 1", out_len); end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [2*VL-1:0][DW-1:0] exp_vec;
        int valid_cnt;
        for (int e = 0; e < 2*VL; e++) exp_vec[e] = DW'(e + 1);
        drive_pair(8'hA1, 8'hA2, 1'b0);
        drive_pair(8'hA3, 8'hA4, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'hEE;
        in_b     = 8'hEE;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_len !== 3'd0 || data_out !== 64'h0) begin
            fails++; $display("FAIL midrst_cleared got v=%b len=%0d %h want 0", out_valid, out_len, data_out);
        end
        valid_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < VL) begin
                in_valid = 1'b1;
                in_a     = DW'(2*c + 1);
                in_b     = DW'(2*c + 2);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid === 1'b1) begin
                valid_cnt++;
                tests_run++;
                if (data_out !== exp_vec || out_len !== 3'd4) begin
                    fails++; $display("FAIL midrst_data got %h len=%0d want %h len=4", data_out, out_len, exp_vec);
                end
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (valid_cnt != 1) begin fails++; $display("FAIL midrst_valid_count got %0d want 1", valid_cnt); end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full();
        test_short();
        test_backpressure();
        test_single();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
